vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing source for the 800x600@60 Hz display path, run from the 40 MHz pixel clock.
- Produces HS, VS, blank, row and col for the paddle/ball draw logic and the VGA-to-HDMI converter.
- Adds frame/line start strobes, a frame counter, and a configurable sync/blank delay so that draw logic with pipeline latency stays pixel-aligned.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, horizontal sync width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, HS active level
- VS_POL, 1, VS active level
- PIPE_DLY, 0, extra clocks of delay on HS/VS/blank/strobes (range 0..7)

Ports:
- clock  in  1  40 MHz pixel clock
- reset_n  in  1  asynchronous, active-low reset
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- blank  out  1  1 = outside visible area
- row  out  10  visible line index
- col  out  10  visible pixel index
- line_start  out  1  one-clock pulse at col 0 of every line, including blanked lines
- frame_start  out  1  one-clock pulse at row 0, col 0
- frame_count  out  8  frames started since reset, wraps
- red, green, blue  out  8 each  test pattern output (see Optional Feature)

Behaviour:
- Counters
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H params = 1056. Wraps to 0.
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL = 628. Increments when h_cnt wraps; wraps to 0 after V_TOTAL-1.
  - Counter widths: h 11 bits, v 10 bits.
- Decode, all outputs registered from counter state:
  - blank = (h_cnt >= H_ACTIVE) | (v_cnt >= V_ACTIVE)
  - HS active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [840, 968)
  - VS active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [601, 605), for full lines
  - col = h_cnt[9:0] when h_cnt < H_ACTIVE, else 0
  - row = v_cnt[9:0] when v_cnt < V_ACTIVE, else 0
  - line_start when h_cnt == 0; frame_start when h_cnt == 0 and v_cnt == 0
  - frame_count increments on the same edge that asserts frame_start; 255 -> 0
- Reset
  - While reset_n = 0: h_cnt = v_cnt = 0, HS = ~HS_POL, VS = ~VS_POL, blank = 1, row = col = 0, strobes = 0, frame_count = 0, RGB = 0.
  - Every delay stage is cleared to the same idle values.
- Start-up timing
  - First rising edge after reset_n deasserts (PIPE_DLY = 0): col = 0, row = 0, blank = 0, line_start = frame_start = 1, frame_count = 1.
  - Line period is exactly 1056 clocks; frame period is exactly 663168 clocks.
- PIPE_DLY
  - HS, VS, blank, line_start, frame_start and RGB pass through a PIPE_DLY-deep register chain.
  - row, col and frame_count are NOT delayed, so downstream logic with PIPE_DLY latency lands color on the matching sync/blank.
  - PIPE_DLY = 0: no chain.
- Reset mid-frame: asynchronous return to the reset state; restart from (0,0) with frame_count = 1 on the first edge after release.
- No enable input; the block counts every clock outside reset.

Optional Feature:
- Macro: VGA_TIMING_TESTPATTERN_EN
- Defined: red/green/blue drive 8 vertical color bars, 100 columns each, indexed by col, in this order:
  - white FF/FF/FF
  - yellow FF/FF/00
  - cyan 00/FF/FF
  - green 00/FF/00
  - magenta FF/00/FF
  - red FF/00/00
  - blue 00/00/FF
  - black 00/00/00
  - RGB = 0 whenever blank. RGB is aligned with blank at the output, including PIPE_DLY.
- Undefined: red/green/blue tied to 0 and no pattern logic synthesized.

Test Plan:
- Hold reset_n = 0 for 10 clocks -> HS = 0, VS = 0, blank = 1, row = col = 0, frame_count = 0; release -> first edge col = 0, row = 0, blank = 0, frame_start = 1, frame_count = 1.
- Run one line from frame start -> blank rises at clock 800, HS high for clocks 840..967, next line_start at clock 1056 with row = 1.
- Run two frames -> VS high for exactly 4 lines starting at line 601 (4224 clocks); frame_start pulses 663168 clocks apart; blank high for all of lines 600..627.
- Force 256 frames (or preload frame_count via a bench hook) -> frame_count wraps 255 -> 0 on the frame_start edge.
- PIPE_DLY = 2 -> HS/VS/blank/frame_start each lag the PIPE_DLY = 0 reference by exactly 2 clocks; row/col unchanged.
- Reset pulse at row 300, col 400 -> all outputs return to reset values asynchronously, then restart at (0,0) with frame_count = 1.
- With VGA_TIMING_TESTPATTERN_EN, row 10:
  - col 0 -> FF/FF/FF
  - col 150 -> FF/FF/00
  - col 799 -> 00/00/00
  - col 850 (blanked) -> 0/0/0

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 800x600@60 raster timing generator with strobes, frame counter and sync delay
//
// Ports:
//   clock        in   pixel clock (40 MHz)
//   reset_n      in   asynchronous active-low reset
//   HS, VS       out  horizontal / vertical sync (active level HS_POL / VS_POL)
//   blank        out  1 = outside visible area
//   row, col     out  visible line / pixel index, 0 while blanked
//   line_start   out  one-clock pulse at h_cnt == 0 of every line
//   frame_start  out  one-clock pulse at h_cnt == 0, v_cnt == 0
//   frame_count  out  frames started since reset, wraps at 256
//   red/green/blue out test pattern (color bars) when VGA_TIMING_TESTPATTERN_EN is defined, else 0
//
// HS, VS, blank, line_start, frame_start and RGB are delayed by PIPE_DLY extra
// clocks; row, col and frame_count are not, so draw logic with PIPE_DLY latency
// lands its color on the matching sync/blank.

module vga_timing_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   PIPE_DLY = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       HS,
  output logic       VS,
  output logic       blank,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // Delayed bundle: {HS, VS, blank, line_start, frame_start, red, green, blue}
  localparam int          BW   = 29;
  localparam logic [BW-1:0] IDLE = {~HS_POL, ~VS_POL, 1'b1, 2'b00, 24'h000000};

  logic [10:0]   h_cnt;
  logic [9:0]    v_cnt;
  logic          h_vis, v_vis;
  logic          blank_d, hs_d, vs_d, ls_d, fs_d;
  logic [23:0]   rgb_d;
  logic [BW-1:0] bus_d, bus_q, bus_o;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  always_comb begin
    h_vis   = (h_cnt < H_VIS);
    v_vis   = (v_cnt < V_VIS);
    blank_d = !(h_vis && v_vis);
    hs_d    = (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
    vs_d    = (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;
    ls_d    = (h_cnt == 11'd0);
    fs_d    = ls_d && (v_cnt == 10'd0);
  end

`ifdef VGA_TIMING_TESTPATTERN_EN
  // Eight 100-column bars across the visible line, black while blanked.
  always_comb begin
    rgb_d = 24'h000000;
    if (!blank_d) begin
      if      (h_cnt < 11'd100) rgb_d = 24'hFFFFFF;
      else if (h_cnt < 11'd200) rgb_d = 24'hFFFF00;
      else if (h_cnt < 11'd300) rgb_d = 24'h00FFFF;
      else if (h_cnt < 11'd400) rgb_d = 24'h00FF00;
      else if (h_cnt < 11'd500) rgb_d = 24'hFF00FF;
      else if (h_cnt < 11'd600) rgb_d = 24'hFF0000;
      else if (h_cnt < 11'd700) rgb_d = 24'h0000FF;
      else                      rgb_d = 24'h000000;
    end
  end
`else
  assign rgb_d = 24'h000000;
`endif

  assign bus_d = {hs_d, vs_d, blank_d, ls_d, fs_d, rgb_d};

  // Output register stage; frame_count steps on the edge that raises frame_start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_q       <= IDLE;
      row         <= '0;
      col         <= '0;
      frame_count <= '0;
    end else begin
      bus_q       <= bus_d;
      row         <= v_vis ? v_cnt : 10'd0;
      col         <= h_vis ? h_cnt[9:0] : 10'd0;
      frame_count <= frame_count + {7'd0, fs_d};
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign bus_o = bus_q;
    end else begin : g_dly
      logic [BW-1:0] dly [PIPE_DLY];
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_DLY; i++) dly[i] <= IDLE;
        end else begin
          dly[0] <= bus_q;
          for (int i = 1; i < PIPE_DLY; i++) dly[i] <= dly[i-1];
        end
      end
      assign bus_o = dly[PIPE_DLY-1];
    end
  endgenerate

  assign {HS, VS, blank, line_start, frame_start, red, green, blue} = bus_o;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against an arithmetic raster model

module tb_vga_timing_gen;

  localparam int SHA = 8, SHF = 2, SHW = 3, SHB = 2;
  localparam int SVA = 4, SVF = 1, SVW = 2, SVB = 1;
  localparam int S_FRAME = (SHA + SHF + SHW + SHB) * (SVA + SVF + SVW + SVB);

`ifdef VGA_TIMING_TESTPATTERN_EN
  localparam logic [23:0] P_C0   = 24'hFFFFFF;
  localparam logic [23:0] P_C150 = 24'hFFFF00;
`else
  localparam logic [23:0] P_C0   = 24'h000000;
  localparam logic [23:0] P_C150 = 24'h000000;
`endif

  typedef struct packed {
    logic       hs, vs, blank, ls, fs;
    logic [9:0] row, col;
    logic [7:0] fc;
    logic [23:0] rgb;
  } vexp_t;

  logic clock = 1'b0;
  logic reset_n;

  logic       hs0, vs0, bl0, ls0, fs0, hss, vss, bls, lss, fss, hsd, vsd, bld, lsd, fsd;
  logic [9:0] row0, col0, rows, cols, rowd, cold;
  logic [7:0] fc0, r0, g0, b0, fcs, rs, gs, bs, fcd, rd, gd, bd;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int last_ls0 = -1;
  int last_fss = -1;

  always #5 clock = ~clock;

  vga_timing_gen u_full (
    .clock(clock), .reset_n(reset_n), .HS(hs0), .VS(vs0), .blank(bl0), .row(row0), .col(col0),
    .line_start(ls0), .frame_start(fs0), .frame_count(fc0), .red(r0), .green(g0), .blue(b0)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHW), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVW), .V_BP(SVB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0)
  ) u_small (
    .clock(clock), .reset_n(reset_n), .HS(hss), .VS(vss), .blank(bls), .row(rows), .col(cols),
    .line_start(lss), .frame_start(fss), .frame_count(fcs), .red(rs), .green(gs), .blue(bs)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHW), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVW), .V_BP(SVB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(2)
  ) u_dly (
    .clock(clock), .reset_n(reset_n), .HS(hsd), .VS(vsd), .blank(bld), .row(rowd), .col(cold),
    .line_start(lsd), .frame_start(fsd), .frame_count(fcd), .red(rd), .green(gd), .blue(bd)
  );

  function automatic logic [23:0] bar_rgb(int h);
`ifdef VGA_TIMING_TESTPATTERN_EN
    case (h / 100)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
`else
    return 24'h000000 | 24'(h & 0);
`endif
  endfunction

  // Expected outputs seen after the edge with index tt (tt = 0 is the first edge after release).
  function automatic vexp_t model(int tt, int ha, int hf, int hw, int hb,
                                  int va, int vf, int vw, int vb, logic hp, logic vp);
    vexp_t e;
    int htot, vtot, h, v;
    e = '0;
    if (tt < 0) begin
      e.hs = ~hp; e.vs = ~vp; e.blank = 1'b1;
      return e;
    end
    htot = ha + hf + hw + hb;
    vtot = va + vf + vw + vb;
    h = tt % htot;
    v = (tt / htot) % vtot;
    e.blank = (h >= ha) || (v >= va);
    e.hs    = (h >= ha + hf && h < ha + hf + hw) ? hp : ~hp;
    e.vs    = (v >= va + vf && v < va + vf + vw) ? vp : ~vp;
    e.col   = (h < ha) ? 10'(h) : 10'd0;
    e.row   = (v < va) ? 10'(v) : 10'd0;
    e.ls    = (h == 0);
    e.fs    = (h == 0) && (v == 0);
    e.fc    = 8'((tt / (htot * vtot) + 1) % 256);
    e.rgb   = e.blank ? 24'h0 : bar_rgb(h);
    return e;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_idle(string tag);
    check({tag, "_full"},  64'({hs0, vs0, bl0, ls0, fs0, row0, col0, fc0, r0, g0, b0}),
          64'({1'b0, 1'b0, 1'b1, 2'b00, 10'd0, 10'd0, 8'd0, 24'h0}));
    check({tag, "_small"}, 64'({hss, vss, bls, lss, fss, rows, cols, fcs, rs, gs, bs}),
          64'({1'b1, 1'b1, 1'b1, 2'b00, 10'd0, 10'd0, 8'd0, 24'h0}));
    check({tag, "_dly"},   64'({hsd, vsd, bld, lsd, fsd, rowd, cold, fcd, rd, gd, bd}),
          64'({1'b1, 1'b1, 1'b1, 2'b00, 10'd0, 10'd0, 8'd0, 24'h0}));
  endtask

  task automatic check_all();
    vexp_t m, ms, md;
    m  = model(t,     800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
    ms = model(t,     SHA, SHF, SHW, SHB, SVA, SVF, SVW, SVB, 1'b0, 1'b0);
    md = model(t - 2, SHA, SHF, SHW, SHB, SVA, SVF, SVW, SVB, 1'b0, 1'b0);

    check("full_sync", 64'({hs0, vs0, bl0, ls0, fs0}), 64'({m.hs, m.vs, m.blank, m.ls, m.fs}));
    check("full_pos",  64'({row0, col0}), 64'({m.row, m.col}));
    check("full_fc",   64'(fc0), 64'(m.fc));
    check("full_rgb",  64'({r0, g0, b0}), 64'(m.rgb));

    check("small_sync", 64'({hss, vss, bls, lss, fss}), 64'({ms.hs, ms.vs, ms.blank, ms.ls, ms.fs}));
    check("small_pos",  64'({rows, cols}), 64'({ms.row, ms.col}));
    check("small_fc",   64'(fcs), 64'(ms.fc));
    check("small_rgb",  64'({rs, gs, bs}), 64'(ms.rgb));

    check("dly_sync", 64'({hsd, vsd, bld, lsd, fsd}), 64'({md.hs, md.vs, md.blank, md.ls, md.fs}));
    check("dly_pos",  64'({rowd, cold}), 64'({ms.row, ms.col}));
    check("dly_fc",   64'(fcd), 64'(ms.fc));
    check("dly_rgb",  64'({rd, gd, bd}), 64'(md.rgb));

    if (t == 0) check("first_edge", 64'({row0, col0, bl0, fs0, fc0}), 64'({10'd0, 10'd0, 1'b0, 1'b1, 8'd1}));
    if (ls0 === 1'b1) begin
      if (last_ls0 >= 0) check("line_period", 64'(t - last_ls0), 64'd1056);
      last_ls0 = t;
    end
    if (fss === 1'b1) begin
      if (last_fss >= 0) check("frame_period", 64'(t - last_fss), 64'(S_FRAME));
      last_fss = t;
    end
    if (t == 800)  check("blank_rise", 64'(bl0), 64'd1);
    if (t == 839)  check("hs_before",  64'(hs0), 64'd0);
    if (t == 840)  check("hs_first",   64'(hs0), 64'd1);
    if (t == 967)  check("hs_last",    64'(hs0), 64'd1);
    if (t == 968)  check("hs_after",   64'(hs0), 64'd0);
    if (t == 1056) check("line1_row",  64'({ls0, row0}), 64'({1'b1, 10'd1}));
    if (t == 10 * 1056)       check("bar_col0",   64'({row0, r0, g0, b0}), 64'({10'd10, P_C0}));
    if (t == 10 * 1056 + 150) check("bar_col150", 64'({r0, g0, b0}), 64'(P_C150));
    if (t == 10 * 1056 + 799) check("bar_col799", 64'({col0, r0, g0, b0}), 64'({10'd799, 24'h0}));
    if (t == 10 * 1056 + 850) check("bar_col850", 64'({bl0, r0, g0, b0}), 64'({1'b1, 24'h0}));
    if (t == 254 * S_FRAME) check("fc_255",  64'({fss, fcs}), 64'({1'b1, 8'd255}));
    if (t == 255 * S_FRAME) check("fc_wrap", 64'({fss, fcs}), 64'({1'b1, 8'd0}));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      check_all();
      t++;
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n = 1'b1;
    t = 0;
    last_ls0 = -1;
    last_fss = -1;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check_idle("reset_hold");

    release_reset();
    run(31000);

    for (int k = 0; k < 2; k++) begin
      run(int'($urandom_range(200, 2500)));
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check_idle("async_reset");
      repeat (int'($urandom_range(1, 5))) @(posedge clock);
      #1;
      check_idle("reset_held");
      release_reset();
      run(1200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
